// File: rtl/mux32_rr_arbiter.sv
// mux32_rr_arbiter: round-robin owner selection for a shared 32:1 mux with bounded tenure
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   en          - allows a new grant to be issued from IDLE
//   req[31:0]   - per-requester request lines
//   done        - current owner releases the grant
//   sel[4:0]    - registered index of the current (or last) owner
//   grant[31:0] - one-hot owner vector, zero when no owner
//   grant_valid - a grant is held
//   timeout     - one-cycle pulse after a grant is revoked by HOLD_MAX expiry
module mux32_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] req,
    input  logic        done,
    output logic [4:0]  sel,
    output logic [31:0] grant,
    output logic        grant_valid,
    output logic        timeout
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t      r_state, w_state_nxt;
    logic [4:0]  r_sel, r_ptr, w_sel_nxt, w_ptr_nxt, w_win;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_timeout, w_timeout_nxt, w_found, w_expire;
    // Scan from ptr+1 upward; the 5-bit add wraps 31->0 and k=32 lands on ptr itself,
    // so the previous owner is considered last.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!w_found && req[r_ptr + 5'(k)]) begin
                w_win   = r_ptr + 5'(k);
                w_found = 1'b1;
            end
        end
    end
    assign w_expire = r_cnt == 8'(HOLD_MAX);
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (en && w_found) begin
                w_state_nxt = OWN;
                w_sel_nxt   = w_win;
                w_ptr_nxt   = w_win;
                w_cnt_nxt   = 8'd1;
            end
        end else if (done || !req[r_sel] || w_expire) begin
            // done wins over expiry, so timeout only fires for a pure expiry exit
            w_state_nxt   = IDLE;
            w_timeout_nxt = !done && req[r_sel] && w_expire;
        end else begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= 5'd0;
            r_ptr     <= 5'd31;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign sel         = r_sel;
    assign grant_valid = r_state == OWN;
    assign grant       = grant_valid ? 32'd1 << r_sel : 32'd0;
    assign timeout     = r_timeout;
endmodule
